// File: rtl/arbitro_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_pkg
//  Purpose  : Shared constants and helpers for the arbitro_rr transaction
//             arbiter: state encoding, counter width, destination extraction.
//  Revision : 1.0 - initial release
// ============================================================================
package arbitro_pkg;

  // Two-state transfer control encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  // Width of the wrapping transferred-word counter
  localparam int c_GNT_CNT_W = 8;

  // Widest word the destination helper accepts
  localparam int c_MAX_WORD_W = 64;

  // Destination field sits in the top dest_w bits of a data_w-bit word
  function automatic int unsigned dest_of(input logic [c_MAX_WORD_W-1:0] word,
                                          input int data_w,
                                          input int dest_w);
    logic [c_MAX_WORD_W-1:0] shifted;
    logic [c_MAX_WORD_W-1:0] mask;
    shifted = word >> (data_w - dest_w);
    mask    = (c_MAX_WORD_W'(1) << dest_w) - c_MAX_WORD_W'(1);
    return 32'(shifted & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant
//  Purpose  : N-port rotating priority encoder. In rotating mode the search
//             starts at ptr and wraps; in fixed mode it starts at index 0.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant #(
  parameter int N_PORTS = 4,
  parameter int PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               mode,
  output logic [N_PORTS-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  logic [PTR_W-1:0] w_base;

  assign w_base = mode ? ptr : '0;

  // Walk the ports from the base index; N_PORTS is a power of 2 so the
  // PTR_W-bit addition wraps exactly at N_PORTS.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      w_idx = w_base + PTR_W'(k);
      if (!gnt_valid && req[w_idx]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = w_idx;
        gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_rr.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_rr
//  Purpose  : N-port transaction arbiter between show-ahead input FIFOs and
//             output FIFOs. Pops at most one eligible input per cycle and
//             pushes the word, one cycle later, to the FIFO named by its
//             destination field. Backpressure is per destination.
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 10,
  parameter int DEST_W  = $clog2(N_PORTS),
  parameter int RR_MODE = 1
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [N_PORTS-1:0]        empty,
  input  logic [N_PORTS-1:0]        almostfull,
  input  logic [N_PORTS*DATA_W-1:0] data_in,
  output logic [N_PORTS-1:0]        pop,
  output logic [N_PORTS-1:0]        push,
  output logic [DATA_W-1:0]         data_out,
  output logic                      active_out,
  output logic [7:0]                grant_cnt
);

  localparam int c_PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [DATA_W-1:0]      w_head [N_PORTS];
  logic [DEST_W-1:0]      w_dest [N_PORTS];
  logic [N_PORTS-1:0]     w_elig;
  logic [N_PORTS-1:0]     w_gnt;
  logic [c_PTR_W-1:0]     w_gnt_idx;
  logic                   w_gnt_valid;

  logic [0:0]             r_state;
  logic [c_PTR_W-1:0]     r_rr_ptr;
  logic [N_PORTS-1:0]     r_push;
  logic [DATA_W-1:0]      r_data;
  logic [c_GNT_CNT_W-1:0] r_cnt;

  // An input is eligible when it holds a word and that word's destination
  // is not almost full; both flags act in the same cycle they change.
  generate
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      assign w_head[i] = data_in[i*DATA_W +: DATA_W];
      assign w_dest[i] = DEST_W'(dest_of(c_MAX_WORD_W'(w_head[i]), DATA_W, DEST_W));
      assign w_elig[i] = !empty[i] && !almostfull[w_dest[i]];
    end
  endgenerate

  rr_grant #(
    .N_PORTS (N_PORTS),
    .PTR_W   (c_PTR_W)
  ) u_rr_grant (
    .req       (w_elig),
    .ptr       (r_rr_ptr),
    .mode      (RR_MODE != 0),
    .gnt       (w_gnt),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  // Pop goes out in the grant cycle; held low while the arbiter is in reset
  assign pop = reset_L ? w_gnt : '0;

  // Registered transfer stage: state, pointer, pushed word and count advance
  // together on each grant; without a grant the push drops and data holds.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_push   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
    end else if (w_gnt_valid) begin
      r_state  <= XFER;
      r_rr_ptr <= w_gnt_idx + c_PTR_W'(1);
      r_push   <= N_PORTS'(1) << w_dest[w_gnt_idx];
      r_data   <= w_head[w_gnt_idx];
      r_cnt    <= r_cnt + c_GNT_CNT_W'(1);
    end else begin
      r_state  <= IDLE;
      r_push   <= '0;
    end
  end

  assign push       = r_push;
  assign data_out   = r_data;
  assign active_out = (r_state == XFER);
  assign grant_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_rr
//  Purpose  : Self-checking bench for arbitro_rr (N=4, W=10). Input FIFOs are
//             modelled as queues; a reference model predicts pops and pushes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [3:0]  empty, almostfull;
  logic [39:0] data_in;

  logic [3:0] pop_rr, push_rr, pop_fp, push_fp;
  logic [9:0] dout_rr, dout_fp;
  logic       act_rr, act_fp;
  logic [7:0] cnt_rr, cnt_fp;

  always #5 clk = ~clk;

  arbitro_rr #(.N_PORTS(4), .DATA_W(10), .DEST_W(2), .RR_MODE(1)) u_rr (
    .clk(clk), .reset_L(reset_L), .empty(empty), .almostfull(almostfull),
    .data_in(data_in), .pop(pop_rr), .push(push_rr), .data_out(dout_rr),
    .active_out(act_rr), .grant_cnt(cnt_rr));

  arbitro_rr #(.N_PORTS(4), .DATA_W(10), .DEST_W(2), .RR_MODE(0)) u_fp (
    .clk(clk), .reset_L(reset_L), .empty(empty), .almostfull(almostfull),
    .data_in(data_in), .pop(pop_fp), .push(push_fp), .data_out(dout_fp),
    .active_out(act_fp), .grant_cnt(cnt_fp));

  // Input FIFO contents and destination flags
  logic [9:0] q [4][$];
  logic [3:0] af;
  bit         m_rr;

  // Reference model state
  logic [3:0] m_push;
  logic [9:0] m_data;
  logic       m_act;
  logic [7:0] m_cnt;
  int         m_ptr;

  // Per-cycle observed and expected values
  logic [3:0] obs_pop, obs_push, exp_pop, exp_push;
  logic [9:0] obs_data, exp_data;
  logic       obs_act, exp_act;
  logic [7:0] obs_cnt, exp_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  // First eligible port in search order (rotating from the pointer or from 0)
  function automatic int pick();
    int p;
    logic [9:0] h;
    for (int k = 0; k < 4; k++) begin
      p = m_rr ? (m_ptr + k) % 4 : k;
      if (q[p].size() != 0) begin
        h = q[p][0];
        if (!af[h[9:8]]) return p;
      end
    end
    return -1;
  endfunction

  task automatic apply_inputs();
    for (int p = 0; p < 4; p++) begin
      empty[p] = (q[p].size() == 0);
      data_in[p*10 +: 10] = (q[p].size() != 0) ? q[p][0] : 10'($urandom);
    end
    almostfull = af;
  endtask

  task automatic model_reset();
    m_push = '0; m_data = '0; m_act = 1'b0; m_cnt = '0; m_ptr = 0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    for (int p = 0; p < 4; p++) q[p].delete();
    af = '0;
    model_reset();
    apply_inputs();
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  // One clock cycle: drive inputs, sample at negedge, advance the model
  task automatic step();
    int g;
    logic [9:0] w;
    apply_inputs();
    @(negedge clk);
    obs_pop  = m_rr ? pop_rr  : pop_fp;
    obs_push = m_rr ? push_rr : push_fp;
    obs_data = m_rr ? dout_rr : dout_fp;
    obs_act  = m_rr ? act_rr  : act_fp;
    obs_cnt  = m_rr ? cnt_rr  : cnt_fp;
    g = pick();
    exp_pop  = (g >= 0) ? (4'(1) << g) : 4'b0;
    exp_push = m_push; exp_data = m_data; exp_act = m_act; exp_cnt = m_cnt;
    @(posedge clk);
    if (g >= 0) begin
      w      = q[g].pop_front();
      m_data = w;
      m_push = 4'(1) << w[9:8];
      m_act  = 1'b1;
      m_cnt  = m_cnt + 8'd1;
      m_ptr  = (g + 1) % 4;
    end else begin
      m_push = '0;
      m_act  = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    m_rr = 1'b1;
    n_cmp += 4;
    if (push_rr !== 4'b0) begin n_bad++; $display("FAIL reset_push got %b want 0000", push_rr); end
    if (dout_rr !== 10'h0) begin n_bad++; $display("FAIL reset_data got %h want 000", dout_rr); end
    if (cnt_rr !== 8'd0)   begin n_bad++; $display("FAIL reset_cnt got %0d want 0", cnt_rr); end
    if (act_rr !== 1'b0)   begin n_bad++; $display("FAIL reset_active got %b want 0", act_rr); end
    q[0].push_back(10'h2AA);
    step();
    q[1].push_back(10'h1BB);
    apply_inputs();
    #2;
    n_cmp++;
    if (push_rr !== 4'b0100) begin n_bad++; $display("FAIL pre_reset_push got %b want 0100", push_rr); end
    reset_L = 1'b0;
    #1;
    n_cmp += 4;
    if (push_rr !== 4'b0) begin n_bad++; $display("FAIL async_push got %b want 0000", push_rr); end
    if (dout_rr !== 10'h0) begin n_bad++; $display("FAIL async_data got %h want 000", dout_rr); end
    if (cnt_rr !== 8'd0)   begin n_bad++; $display("FAIL async_cnt got %0d want 0", cnt_rr); end
    if (pop_rr !== 4'b0)   begin n_bad++; $display("FAIL async_pop got %b want 0000", pop_rr); end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp += 2;
      if (obs_pop !== 4'b0)  begin n_bad++; $display("FAIL idle_pop[%0d] got %b want 0000", i, obs_pop); end
      if (obs_push !== 4'b0) begin n_bad++; $display("FAIL idle_push[%0d] got %b want 0000", i, obs_push); end
    end
  endtask

  task automatic load_four(int copies);
    logic [9:0] heads [4];
    heads[0] = 10'h0AA; heads[1] = 10'h155; heads[2] = 10'h2F0; heads[3] = 10'h30F;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < copies; c++) q[p].push_back(heads[p]);
  endtask

  task automatic test_round_robin();
    logic [9:0] heads [4];
    heads[0] = 10'h0AA; heads[1] = 10'h155; heads[2] = 10'h2F0; heads[3] = 10'h30F;
    do_reset();
    m_rr = 1'b1;
    load_four(3);
    for (int i = 0; i < 14; i++) begin
      step();
      n_cmp += 5;
      if (obs_pop !== exp_pop)   begin n_bad++; $display("FAIL rr_pop[%0d] got %b want %b", i, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL rr_push[%0d] got %b want %b", i, obs_push, exp_push); end
      if (obs_data !== exp_data) begin n_bad++; $display("FAIL rr_data[%0d] got %h want %h", i, obs_data, exp_data); end
      if (obs_act !== exp_act)   begin n_bad++; $display("FAIL rr_active[%0d] got %b want %b", i, obs_act, exp_act); end
      if (obs_cnt !== exp_cnt)   begin n_bad++; $display("FAIL rr_cnt[%0d] got %0d want %0d", i, obs_cnt, exp_cnt); end
      if (i < 12) begin
        n_cmp++;
        if (obs_pop !== (4'(1) << (i % 4))) begin n_bad++; $display("FAIL rr_order[%0d] got %b want port %0d", i, obs_pop, i % 4); end
      end
      if (i >= 1 && i <= 4) begin
        n_cmp += 2;
        if (obs_push !== (4'(1) << (i - 1))) begin n_bad++; $display("FAIL rr_dest[%0d] got %b want port %0d", i, obs_push, i - 1); end
        if (obs_data !== heads[i-1]) begin n_bad++; $display("FAIL rr_word[%0d] got %h want %h", i, obs_data, heads[i-1]); end
      end
      if (i == 4) begin
        n_cmp++;
        if (obs_cnt !== 8'd4) begin n_bad++; $display("FAIL rr_cnt4 got %0d want 4", obs_cnt); end
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    m_rr = 1'b0;
    load_four(3);
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp += 3;
      if (obs_pop !== exp_pop)   begin n_bad++; $display("FAIL fp_pop[%0d] got %b want %b", i, obs_pop, exp_pop); end
      if (obs_push !== exp_push) begin n_bad++; $display("FAIL fp_push[%0d] got %b want %b", i, obs_push, exp_push); end
      if (obs_cnt !== exp_cnt)   begin n_bad++; $display("FAIL fp_cnt[%0d] got %0d want %0d", i, obs_cnt, exp_cnt); end
      if (i < 3) begin
        n_cmp++;
        if (obs_pop !== 4'b0001) begin n_bad++; $display("FAIL fp_port0[%0d] got %b want 0001", i, obs_pop); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_rr = 1'b1;
    af = 4'b0010;
    q[0].push_back(10'h1AB);
    q[1].push_back(10'h2CD);
    step();
    n_cmp++;
    if (obs_pop !== 4'b0010) begin n_bad++; $display("FAIL bp_skip got %b want 0010", obs_pop); end
    step();
    n_cmp += 2;
    if (obs_push !== 4'b0100) begin n_bad++; $display("FAIL bp_push2 got %b want 0100", obs_push); end
    if (obs_pop !== 4'b0000)  begin n_bad++; $display("FAIL bp_blocked got %b want 0000", obs_pop); end
    af = 4'b0000;
    step();
    n_cmp++;
    if (obs_pop !== 4'b0001) begin n_bad++; $display("FAIL bp_release got %b want 0001", obs_pop); end
    step();
    n_cmp += 2;
    if (obs_push !== 4'b0010) begin n_bad++; $display("FAIL bp_push1 got %b want 0010", obs_push); end
    if (obs_data !== 10'h1AB) begin n_bad++; $display("FAIL bp_data got %h want 1ab", obs_data); end
  endtask

  task automatic test_inflight();
    do_reset();
    m_rr = 1'b1;
    q[2].push_back(10'h3AA);
    q[2].push_back(10'h3BB);
    step();
    n_cmp++;
    if (obs_pop !== 4'b0100) begin n_bad++; $display("FAIL if_grant got %b want 0100", obs_pop); end
    af = 4'b1000;
    q[0].push_back(10'h1DD);
    step();
    n_cmp += 3;
    if (obs_push !== 4'b1000) begin n_bad++; $display("FAIL if_push3 got %b want 1000", obs_push); end
    if (obs_data !== 10'h3AA) begin n_bad++; $display("FAIL if_data got %h want 3aa", obs_data); end
    if (obs_pop !== 4'b0001)  begin n_bad++; $display("FAIL if_other got %b want 0001", obs_pop); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp += 2;
      if (obs_pop[2] !== 1'b0) begin n_bad++; $display("FAIL if_hold[%0d] got pop %b want port2 idle", i, obs_pop); end
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL if_pop[%0d] got %b want %b", i, obs_pop, exp_pop); end
    end
  endtask

  task automatic test_random();
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      m_rr = (mode == 1);
      for (int i = 0; i < 300; i++) begin
        for (int p = 0; p < 4; p++)
          if ($urandom_range(0, 2) == 0 && q[p].size() < 4) q[p].push_back(10'($urandom));
        af = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
        step();
        n_cmp += 5;
        if (obs_pop !== exp_pop)   begin n_bad++; $display("FAIL rand_pop[%0d.%0d] got %b want %b", mode, i, obs_pop, exp_pop); end
        if (obs_push !== exp_push) begin n_bad++; $display("FAIL rand_push[%0d.%0d] got %b want %b", mode, i, obs_push, exp_push); end
        if (obs_data !== exp_data) begin n_bad++; $display("FAIL rand_data[%0d.%0d] got %h want %h", mode, i, obs_data, exp_data); end
        if (obs_act !== exp_act)   begin n_bad++; $display("FAIL rand_active[%0d.%0d] got %b want %b", mode, i, obs_act, exp_act); end
        if (obs_cnt !== exp_cnt)   begin n_bad++; $display("FAIL rand_cnt[%0d.%0d] got %0d want %0d", mode, i, obs_cnt, exp_cnt); end
      end
    end
  endtask

  task automatic test_wrap_idle();
    logic [9:0] lw;
    do_reset();
    m_rr = 1'b1;
    lw = '0;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 64; c++) begin
        lw = 10'($urandom);
        q[p].push_back(lw);
      end
    for (int i = 0; i < 256; i++) begin
      step();
      n_cmp += 2;
      if (obs_pop !== exp_pop) begin n_bad++; $display("FAIL wrap_pop[%0d] got %b want %b", i, obs_pop, exp_pop); end
      if (obs_cnt !== exp_cnt) begin n_bad++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, obs_cnt, exp_cnt); end
    end
    n_cmp++;
    if (obs_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_cnt255 got %0d want 255", obs_cnt); end
    step();
    n_cmp += 3;
    if (obs_cnt !== 8'd0)   begin n_bad++; $display("FAIL wrap_cnt0 got %0d want 0", obs_cnt); end
    if (obs_act !== 1'b1)   begin n_bad++; $display("FAIL wrap_last_active got %b want 1", obs_act); end
    if (obs_pop !== 4'b0)   begin n_bad++; $display("FAIL gap_pop got %b want 0000", obs_pop); end
    for (int p = 0; p < 4; p++) q[p].push_back(10'($urandom));
    step();
    n_cmp += 3;
    if (obs_act !== 1'b0)   begin n_bad++; $display("FAIL gap_active got %b want 0", obs_act); end
    if (obs_data !== lw)    begin n_bad++; $display("FAIL gap_data_hold got %h want %h", obs_data, lw); end
    if (obs_pop !== 4'b0001) begin n_bad++; $display("FAIL gap_ptr_hold got %b want 0001", obs_pop); end
    step();
    n_cmp += 2;
    if (obs_act !== 1'b1)   begin n_bad++; $display("FAIL gap_resume got %b want 1", obs_act); end
    if (obs_pop !== 4'b0010) begin n_bad++; $display("FAIL gap_next got %b want 0010", obs_pop); end
  endtask

  initial begin
    reset_L = 1'b0;
    af = '0;
    m_rr = 1'b1;
    model_reset();
    apply_inputs();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_inflight();
    test_wrap_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Parametrised N-port transaction-layer arbiter between N input FIFOs (show-ahead: head word valid while !empty) and N output FIFOs.
- Each cycle it selects at most one eligible input, pops it and routes the word to the output FIFO named by the word's destination field.
- Arbitration is round-robin or fixed-priority, selected by parameter.
- Backpressure is per destination, so one almost-full output FIFO stalls only the traffic headed for it.
- Outputs are registered: one word and one push per cycle, maximum.

Parameters:
N_PORTS, 4, number of input and output ports; power of 2, ≥2
DATA_W, 10, word width including destination field
DEST_W, $clog2(N_PORTS), destination field width; field occupies data[DATA_W-1 -: DEST_W]
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (port 0 highest)

Ports:
clk  in  1  clock
reset_L  in  1  asynchronous reset, active-low
empty  in  N_PORTS  input FIFO empty flags, bit i = port i
almostfull  in  N_PORTS  output FIFO almost-full flags
data_in  in  N_PORTS*DATA_W  input FIFO heads, port i at [i*DATA_W +: DATA_W]
pop  out  N_PORTS  pop strobes to input FIFOs, combinational, one-hot or zero
push  out  N_PORTS  push strobes to output FIFOs, registered, one-hot or zero
data_out  out  DATA_W  registered word, shared by all output FIFOs
active_out  out  1  registered; 1 while a push is being issued
grant_cnt  out  8  registered, wrapping count of words transferred

Behaviour:
- Reset (reset_L=0, async): push=0, data_out=0, active_out=0, grant_cnt=0, rr_ptr=0. pop is forced to 0 while reset_L=0.
- Eligibility, combinational: elig[i] = !empty[i] && !almostfull[dest(head_i)], where dest(head_i) = data_in slice i [DATA_W-1 -: DEST_W].
- Fixed-priority mode (RR_MODE=0): grant the lowest eligible index.
- Round-robin mode (RR_MODE=1): grant the first eligible index at or above rr_ptr, wrapping modulo N_PORTS.
- rr_ptr update: on a grant to port g, rr_ptr <= (g+1) mod N_PORTS. With no grant, rr_ptr holds.
- pop: pop[g]=1 in the same cycle as the grant. pop is never asserted to an empty FIFO.
- Pipeline, 1-cycle latency: at the clock edge after pop[g]:
  - data_out <= head_g
  - push[dest(head_g)] <= 1
  - active_out <= 1
  - grant_cnt <= grant_cnt+1 (wraps 255→0)
- No grant in a cycle: next cycle push=0, active_out=0, data_out holds its last value.
- Two-state control (IDLE, XFER):
  - IDLE→XFER on any grant.
  - XFER→XFER while grants continue.
  - XFER→IDLE on a cycle without a grant.
  - push/active_out reflect the state registered at that edge.
- Throughput: back-to-back grants allowed; one word per cycle sustained.
- In-flight word: a push issued in the cycle a destination's almostfull rises is still completed. The almost-full threshold must leave ≥1 free slot; this is a system constraint documented for FIFO instances.
- Head-of-line: an input whose head targets a blocked destination is skipped. Other inputs proceed.
- All empty, or all heads blocked: pop=0, rr_ptr holds.
- Simultaneous flags: an empty and an almostfull change in the same cycle both affect that cycle's eligibility.
- Reset mid-transfer: the pending push is dropped and the popped word is lost; the system must reset FIFOs together with the arbiter.
- Outputs never carry X after reset. No latches: every combinational path has default assignments.

Decomposition:
- Package arbitro_pkg holds:
  - state encoding localparams IDLE=1'b0, XFER=1'b1
  - dest-field extraction function
  - grant-count width constant (8)
- One natural sub-module: rr_grant, the N-port rotating priority encoder.
  - Inputs: req[N], ptr[log2 N], mode.
  - Outputs: gnt one-hot, gnt_idx, gnt_valid.
  - It is combinational and reused by future output-side schedulers.
- Top level holds the pipeline register, rr_ptr, FSM and counter.

Test Plan:
1. Reset checks (N=4, W=10):
   - Assert reset_L=0 mid-stream with push[2]=1 → push=0, data_out=0, grant_cnt=0 immediately, without waiting for a clock edge.
   - After release with all empty=1 → pop=0 and push=0 indefinitely.
2. Round-robin fairness:
   - Ports 0..3 non-empty with heads 0x0AA, 0x155, 0x2F0, 0x30F; no almostfull.
   - Required pops: 0,1,2,3,0,...
   - Pushes one cycle later: push[0],[1],[2],[3] with data_out 0x0AA, 0x155, 0x2F0, 0x30F.
   - grant_cnt=4 after four grants.
3. Fixed priority: RR_MODE=0, same stimulus as scenario 2 → pop[0] every cycle while port 0 stays non-empty; ports 1..3 starved.
4. Per-destination backpressure:
   - almostfull[1]=1; port0 head 0x1xx, port1 head 0x2xx.
   - Required: port0 skipped, pop[1]=1, next-cycle push[2]=1, push[1] never asserted.
   - Release almostfull[1] → port0 granted on the next cycle.
5. In-flight word:
   - Grant a word to dest 3 in cycle t; raise almostfull[3] in cycle t+1.
   - Required: push[3]=1 in t+1; no further grants to dest-3 heads from t+1 on.
6. Wrap and idle:
   - 256 transfers → grant_cnt wraps to 0.
   - A gap cycle with all empty → active_out drops to 0 for exactly one cycle, data_out holds, rr_ptr unchanged.
